// File: rtl/pmu_snapshot_reader.sv
// pmu_snapshot_reader
// Waits for all loaders to go idle, then reads counter 0..NUM_COUNTERS-1
// from all N PMUs, one counter index at a time, and streams the values out.
// Beats are counter-major: every PMU for counter 0, then every PMU for
// counter 1, and so on.
//
// State table:
//   IDLE      | waiting for trigger_i, c = 0
//   WAIT_IDLE | waiting for every idle_i bit to be high on the same cycle
//   ADDR      | pmu_addr_o = c, waiting PMU_RD_LAT cycles for the read data
//   CAPTURE   | latch all N pmu_data_i into the local buffer
//   STREAM    | present buffer[p] with tuser = {c, p}
//   DONE      | one-cycle done_o pulse, then back to IDLE
//
// Ports:
//   aclk, aresetn      clock, asynchronous active-low reset
//   trigger_i          snapshot request, sampled only in IDLE
//   idle_i[N]          loader idle flags
//   pmu_addr_o[N]      counter index, the same value on every PMU
//   pmu_data_i[N]      PMU read data
//   m_t*               stream: valid/ready/data/user={c,p}/last
//   busy_o             high in every state except IDLE
//   done_o             one-cycle pulse after the final handshake
module pmu_snapshot_reader #(
  parameter int N              = 16,
  parameter int NUM_COUNTERS   = 32,
  parameter int PMU_ADDR_WIDTH = 5,
  parameter int PMU_DATA_WIDTH = 64,
  parameter int PMU_RD_LAT     = 1,
  localparam int CW = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      trigger_i,
  input  logic [N-1:0]              idle_i,
  output logic [PMU_ADDR_WIDTH-1:0] pmu_addr_o [N],
  input  logic [PMU_DATA_WIDTH-1:0] pmu_data_i [N],
  output logic                      m_tvalid_o,
  input  logic                      m_tready_i,
  output logic [PMU_DATA_WIDTH-1:0] m_tdata_o,
  output logic [CW+PW-1:0]          m_tuser_o,
  output logic                      m_tlast_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int LW = (PMU_RD_LAT > 1) ? $clog2(PMU_RD_LAT) : 1;
  localparam logic [LW-1:0] LAT_LOAD = (PMU_RD_LAT > 0) ? LW'(PMU_RD_LAT - 1) : '0;
  localparam logic [CW-1:0] C_LAST = CW'(NUM_COUNTERS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_IDLE = 3'd1,
    S_ADDR      = 3'd2,
    S_CAPTURE   = 3'd3,
    S_STREAM    = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CW-1:0]             r_c;
  logic [PW-1:0]             r_p;
  logic [LW-1:0]             r_lat_cnt;
  logic [PMU_DATA_WIDTH-1:0] r_buf [N];

  logic w_hs;
  logic w_p_last;
  logic w_c_last;

  assign w_hs     = (r_state == S_STREAM) && m_tready_i;
  assign w_p_last = (r_p == P_LAST);
  assign w_c_last = (r_c == C_LAST);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (trigger_i) w_state_nxt = S_WAIT_IDLE;
      S_WAIT_IDLE: if (&idle_i) w_state_nxt = (PMU_RD_LAT > 0) ? S_ADDR : S_CAPTURE;
      S_ADDR:      if (r_lat_cnt == '0) w_state_nxt = S_CAPTURE;
      S_CAPTURE:   w_state_nxt = S_STREAM;
      S_STREAM: begin
        if (w_hs && w_p_last) begin
          if (w_c_last)             w_state_nxt = S_DONE;
          else if (PMU_RD_LAT > 0)  w_state_nxt = S_ADDR;
          else                      w_state_nxt = S_CAPTURE;
        end
      end
      S_DONE:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_c       <= '0;
      r_p       <= '0;
      r_lat_cnt <= '0;
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
    end else begin
      // Reloaded whenever we are outside ADDR, so it is always fresh on entry.
      if (r_state != S_ADDR)      r_lat_cnt <= LAT_LOAD;
      else if (r_lat_cnt != '0)   r_lat_cnt <= r_lat_cnt - LW'(1);

      case (r_state)
        S_IDLE: begin
          if (trigger_i) begin
            r_c <= '0;
            r_p <= '0;
          end
        end
        S_CAPTURE: begin
          for (int i = 0; i < N; i++) r_buf[i] <= pmu_data_i[i];
          r_p <= '0;
        end
        S_STREAM: begin
          if (w_hs) begin
            if (!w_p_last) begin
              r_p <= r_p + PW'(1);
            end else begin
              r_p <= '0;
              // c drives the PMU address, so clearing it here parks the
              // address at 0 for DONE and IDLE.
              r_c <= w_c_last ? '0 : r_c + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) pmu_addr_o[i] = PMU_ADDR_WIDTH'(r_c);
  end

  assign m_tvalid_o = (r_state == S_STREAM);
  assign m_tdata_o  = r_buf[r_p];
  assign m_tuser_o  = {r_c, r_p};
  assign m_tlast_o  = (r_state == S_STREAM) && w_p_last && w_c_last;
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = (r_state == S_DONE);

endmodule

// File: tb/tb_pmu_snapshot_reader.sv
module tb_pmu_snapshot_reader;

  localparam int N  = 4;
  localparam int NC = 2;

  logic aclk = 1'b0;
  logic aresetn;
  logic trig_a, trig_b;
  logic [N-1:0] idle;
  logic tready;
  logic sel;

  logic [4:0]  addr_a [N];
  logic [4:0]  addr_b [N];
  logic [63:0] data_a [N];
  logic [63:0] data_b [N];

  logic        tvalid_a, tlast_a, busy_a, done_a;
  logic        tvalid_b, tlast_b, busy_b, done_b;
  logic [63:0] tdata_a, tdata_b;
  logic [2:0]  tuser_a, tuser_b;

  logic        v, l, dn, bz;
  logic [63:0] d;
  logic [2:0]  u;
  logic [4:0]  a0, a3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 aclk = ~aclk;

  pmu_snapshot_reader #(.N(N), .NUM_COUNTERS(NC), .PMU_ADDR_WIDTH(5),
                        .PMU_DATA_WIDTH(64), .PMU_RD_LAT(1)) dut (
    .aclk(aclk), .aresetn(aresetn), .trigger_i(trig_a), .idle_i(idle),
    .pmu_addr_o(addr_a), .pmu_data_i(data_a),
    .m_tvalid_o(tvalid_a), .m_tready_i(tready), .m_tdata_o(tdata_a),
    .m_tuser_o(tuser_a), .m_tlast_o(tlast_a), .busy_o(busy_a), .done_o(done_a));

  pmu_snapshot_reader #(.N(N), .NUM_COUNTERS(NC), .PMU_ADDR_WIDTH(5),
                        .PMU_DATA_WIDTH(64), .PMU_RD_LAT(0)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .trigger_i(trig_b), .idle_i(idle),
    .pmu_addr_o(addr_b), .pmu_data_i(data_b),
    .m_tvalid_o(tvalid_b), .m_tready_i(tready), .m_tdata_o(tdata_b),
    .m_tuser_o(tuser_b), .m_tlast_o(tlast_b), .busy_o(busy_b), .done_o(done_b));

  // PMU models: data = {addr, node}; one-cycle registered read and combinational read.
  always @(posedge aclk) begin
    for (int i = 0; i < N; i++) data_a[i] <= (64'(addr_a[i]) << 8) | 64'(i);
  end

  always_comb begin
    for (int i = 0; i < N; i++) data_b[i] = (64'(addr_b[i]) << 8) | 64'(i);
  end

  always_comb begin
    if (sel) begin
      v = tvalid_b; l = tlast_b; dn = done_b; bz = busy_b; d = tdata_b; u = tuser_b;
      a0 = addr_b[0]; a3 = addr_b[N-1];
    end else begin
      v = tvalid_a; l = tlast_a; dn = done_a; bz = busy_a; d = tdata_a; u = tuser_a;
      a0 = addr_a[0]; a3 = addr_a[N-1];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one snapshot from the current negedge for a fixed 80-cycle window.
  task automatic snap(input bit s, input int stall_pct, input int idle_hold,
                      input int trig_beat, input int exp_first, input int exp_period);
    int beat, dones, first, t4, tl, done_cyc, bfall;
    bit ps, rdy;
    logic [63:0] pd;
    logic [2:0]  pu;
    logic        pl;
    beat = 0; dones = 0; first = -1; t4 = -1; tl = -1; done_cyc = -1; bfall = -1;
    ps = 1'b0; pd = '0; pu = '0; pl = 1'b0;
    sel = s;
    tready = 1'b1;
    if (idle_hold > 0) idle[2] = 1'b0;
    if (s) trig_b = 1'b1; else trig_a = 1'b1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge aclk);
      trig_a = 1'b0;
      trig_b = 1'b0;
      if (idle_hold > 0 && cyc < idle_hold) begin
        chk("wait_tvalid", 64'(v), 64'd0);
        chk("wait_addr", 64'(a0), 64'd0);
        chk("wait_busy", 64'(bz), 64'd1);
      end
      if (cyc == idle_hold) idle[2] = 1'b1;
      if (trig_beat >= 0 && beat == trig_beat) begin
        if (s) trig_b = 1'b1; else trig_a = 1'b1;
      end
      if (dn) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && bfall < 0 && !bz) bfall = cyc;
      if (ps) begin
        chk("hold_valid", 64'(v), 64'd1);
        chk("hold_data", d, pd);
        chk("hold_user", 64'(u), 64'(pu));
        chk("hold_last", 64'(l), 64'(pl));
      end
      rdy = 1'b1;
      if (v) begin
        if (first < 0) first = cyc;
        rdy = ($urandom_range(99) >= stall_pct);
        if (rdy) begin
          chk("tdata", d, 64'(((beat / N) << 8) | (beat % N)));
          chk("tuser", 64'(u), 64'(beat % 8));
          chk("tlast", 64'(l), 64'(beat == N*NC-1));
          chk("addr0", 64'(a0), 64'(beat / N));
          chk("addr3", 64'(a3), 64'(beat / N));
          if (beat == N) t4 = cyc;
          if (beat == N*NC-1) tl = cyc;
          beat++;
        end
        ps = !rdy; pd = d; pu = u; pl = l;
      end else begin
        ps = 1'b0;
      end
      tready = rdy;
    end
    tready = 1'b1;
    chk("beats", 64'(beat), 64'(N*NC));
    chk("dones", 64'(dones), 64'd1);
    chk("first_valid", 64'(first), 64'(exp_first));
    if (stall_pct == 0) chk("counter_period", 64'(t4 - first), 64'(exp_period));
    chk("done_after_last", 64'(done_cyc), 64'(tl + 1));
    chk("busy_fall", 64'(bfall), 64'(tl + 2));
    chk("end_busy", 64'(bz), 64'd0);
    chk("end_addr", 64'(a0), 64'd0);
  endtask

  initial begin
    int cnt;
    aresetn = 1'b0;
    trig_a = 1'b0; trig_b = 1'b0;
    idle = '1;
    tready = 1'b1;
    sel = 1'b0;
    #2;
    chk("rst_tvalid", 64'(tvalid_a), 64'd0);
    chk("rst_tlast", 64'(tlast_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_tdata", tdata_a, 64'd0);
    chk("rst_tuser", 64'(tuser_a), 64'd0);
    chk("rst_addr", 64'(addr_a[0]), 64'd0);
    chk("rst_busy0", 64'(busy_b), 64'd0);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    // Basic snapshot, one-cycle PMU latency.
    snap(1'b0, 0, 0, -1, 4, 6);
    // idle_i[2] low for 10 cycles after the trigger.
    snap(1'b0, 0, 10, -1, 13, 6);
    // Random stalls.
    snap(1'b0, 30, 0, -1, 4, 6);
    // Combinational PMU.
    snap(1'b1, 0, 0, -1, 3, 5);
    snap(1'b1, 30, 0, -1, 3, 5);

    // Reset during beat 5.
    sel = 1'b0;
    tready = 1'b1;
    trig_a = 1'b1;
    @(negedge aclk);
    trig_a = 1'b0;
    cnt = 0;
    while (!(v && u == 3'd4) && cnt < 40) begin
      @(negedge aclk);
      cnt++;
    end
    chk("reach_beat5", 64'(v && u == 3'd4), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(tvalid_a), 64'd0);
    chk("midrst_busy", 64'(busy_a), 64'd0);
    chk("midrst_addr", 64'(addr_a[0]), 64'd0);
    chk("midrst_tuser", 64'(tuser_a), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    snap(1'b0, 0, 0, -1, 4, 6);

    // Trigger pulsed while streaming is ignored.
    snap(1'b0, 0, 0, 2, 4, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
